// File: rtl/sample_msg_combiner_pkg.sv
// Types shared by the sample/message combiner and its sub-blocks.
`ifndef SAMPLE_MSG_DEFINES_SV
`include "sample_msg_defines.sv"
`endif

package sample_msg_combiner_pkg;

  localparam int unsigned LEN_W = `MSG_LENGTH_WIDTH;

  typedef logic [LEN_W-1:0] msg_len_t;

  typedef enum logic {
    ST_IDLE,
    ST_MSG
  } out_state_e;

endpackage

// File: rtl/sample_msg_combiner_sync_fifo.sv
// Single-clock FIFO with fall-through read data; writes when full and reads
// when empty are ignored.
module sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               rd_en,
  output logic [WIDTH-1:0]   rd_data,
  output logic               full,
  output logic               empty,
  output logic [LOG_DEPTH:0] count
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH-1:0] PTR_ONE = 1;
  localparam logic [LOG_DEPTH:0]   CNT_ONE = 1;

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG_DEPTH:0]   count_q, count_d;
  logic                 do_wr, do_rd;

  assign full    = count_q[LOG_DEPTH];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sample_msg_defines.sv
// Shared mixed-stream message framing macros, used by both the splitter and the combiner.
`ifndef SAMPLE_MSG_DEFINES_SV
`define SAMPLE_MSG_DEFINES_SV

`define MSG_LENGTH_WIDTH 16
`define MSG_HDR_BIT(w) ((w)-1)
`define MSG_LEN_SLICE(w) [(w)-2 -: `MSG_LENGTH_WIDTH]

`endif

// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a message stream into one mixed stream; messages
// are emitted atomically once fully buffered and take priority over samples.
`ifndef SAMPLE_MSG_DEFINES_SV
`include "sample_msg_defines.sv"
`endif

module sample_msg_combiner
  import sample_msg_combiner_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SAMPLE_BUF_LOG = 4,
  parameter int MSG_BUF_LOG    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_samples,
  input  logic             in_samples_nd,
  input  logic [WIDTH-1:0] in_msg,
  input  logic             in_msg_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             error
);

  localparam int HDR = `MSG_HDR_BIT(WIDTH);
  localparam msg_len_t LEN_ONE = 1;
  localparam logic [MSG_BUF_LOG:0] CNT_ONE = 1;

  logic [WIDTH-1:0]      samp_rd_data, msg_rd_data;
  logic                  samp_wr, samp_rd, samp_full, samp_empty;
  logic                  msg_wr, msg_rd, msg_full, msg_empty;
  logic [SAMPLE_BUF_LOG:0] unused_samp_count;
  logic [MSG_BUF_LOG:0]    unused_msg_count;

  logic                  msg_is_hdr, msg_accept, msg_done, cnt_dec, err_set;
  msg_len_t              msg_hdr_len, pop_len;

  out_state_e            state_q, state_d;
  msg_len_t              in_remaining_q, in_remaining_d;
  msg_len_t              out_remaining_q, out_remaining_d;
  logic [MSG_BUF_LOG:0]  complete_count_q, complete_count_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic                  out_nd_q, out_nd_d;
  logic                  error_q, error_d;

  sync_fifo #(.WIDTH(WIDTH), .LOG_DEPTH(SAMPLE_BUF_LOG)) u_samp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (samp_wr),
    .wr_data (in_samples),
    .rd_en   (samp_rd),
    .rd_data (samp_rd_data),
    .full    (samp_full),
    .empty   (samp_empty),
    .count   (unused_samp_count)
  );

  sync_fifo #(.WIDTH(WIDTH), .LOG_DEPTH(MSG_BUF_LOG)) u_msg_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (msg_wr),
    .wr_data (in_msg),
    .rd_en   (msg_rd),
    .rd_data (msg_rd_data),
    .full    (msg_full),
    .empty   (msg_empty),
    .count   (unused_msg_count)
  );

  // Input side: sample filter, message parser, sticky error.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    samp_wr        = in_samples_nd && !in_samples[HDR] && !samp_full;
    msg_is_hdr     = in_msg[HDR];
    msg_hdr_len    = in_msg `MSG_LEN_SLICE(WIDTH);
    msg_accept     = in_msg_nd && (msg_is_hdr || in_remaining_q != '0);
    msg_wr         = msg_accept && !msg_full;
    in_remaining_d = in_remaining_q;
    msg_done       = 1'b0;
    if (msg_wr) begin
      if (msg_is_hdr) begin
        in_remaining_d = msg_hdr_len;
        msg_done       = (msg_hdr_len == '0);
      end else begin
        in_remaining_d = in_remaining_q - LEN_ONE;
        msg_done       = (in_remaining_q == LEN_ONE);
      end
    end
    err_set = (in_samples_nd && (in_samples[HDR] || samp_full))
           || (in_msg_nd && msg_is_hdr && in_remaining_q != '0)
           || (in_msg_nd && !msg_is_hdr && in_remaining_q == '0)
           || (msg_accept && msg_full);
    error_d = error_q || err_set;
  end

  // Output FSM: at most one pop per cycle, whole messages before samples.
  always_comb begin
    state_d         = state_q;
    out_remaining_d = out_remaining_q;
    out_data_d      = out_data_q;
    out_nd_d        = 1'b0;
    samp_rd         = 1'b0;
    msg_rd          = 1'b0;
    cnt_dec         = 1'b0;
    pop_len         = msg_rd_data `MSG_LEN_SLICE(WIDTH);
    case (state_q)
      ST_IDLE: begin
        if (complete_count_q != '0) begin
          msg_rd          = 1'b1;
          cnt_dec         = 1'b1;
          out_data_d      = msg_rd_data;
          out_nd_d        = 1'b1;
          out_remaining_d = pop_len;
          if (pop_len != '0) state_d = ST_MSG;
        end else if (!samp_empty) begin
          samp_rd    = 1'b1;
          out_data_d = samp_rd_data;
          out_nd_d   = 1'b1;
        end
      end
      ST_MSG: begin
        msg_rd          = 1'b1;
        out_data_d      = msg_rd_data;
        out_nd_d        = !msg_empty;
        out_remaining_d = out_remaining_q - LEN_ONE;
        if (out_remaining_q <= LEN_ONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    case ({msg_done, cnt_dec})
      2'b10:   complete_count_d = complete_count_q + CNT_ONE;
      2'b01:   complete_count_d = complete_count_q - CNT_ONE;
      default: complete_count_d = complete_count_q;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      in_remaining_q   <= '0;
      out_remaining_q  <= '0;
      complete_count_q <= '0;
      out_data_q       <= '0;
      out_nd_q         <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      in_remaining_q   <= in_remaining_d;
      out_remaining_q  <= out_remaining_d;
      complete_count_q <= complete_count_d;
      out_data_q       <= out_data_d;
      out_nd_q         <= out_nd_d;
      error_q          <= error_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule

// File: doc/sample_msg_combiner.md
Name: sample_msg_combiner

Overview:
- Merges a sample stream and a message stream into one mixed stream for downstream message-aware blocks, e.g. onto a single link whose far end separates it again.
- Protocol of the mixed stream: a message header has MSB=1 and carries length L in bits [WIDTH-2 -: `MSG_LENGTH_WIDTH`]; exactly L content words (MSB=0) follow it contiguously; samples have MSB=0.
- Inputs carry no backpressure, so both streams are buffered in FIFOs.
- Messages are emitted atomically and only once fully buffered; they have priority over samples.

Parameters:
- WIDTH, 32, word width.
- SAMPLE_BUF_LOG, 4, log2 of sample FIFO depth.
- MSG_BUF_LOG, 5, log2 of message FIFO depth; must satisfy 2^MSG_BUF_LOG >= max L + 1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_samples  input  WIDTH  sample word.
- in_samples_nd  input  1  in_samples valid this cycle.
- in_msg  input  WIDTH  message word (header or content).
- in_msg_nd  input  1  in_msg valid this cycle.
- out_data  output  WIDTH  merged stream word.
- out_nd  output  1  out_data valid this cycle.
- error  output  1  sticky protocol or overflow error.

Behaviour:
- Reset (rst_n low, asynchronous): out_nd=0, out_data=0, error=0. Both FIFOs empty, complete_count=0, in_remaining=0, out_remaining=0, state=IDLE. Reset asserted mid-message discards everything buffered.
- Sample input:
  - in_samples_nd with MSB=0 is written to the sample FIFO.
  - MSB=1 sets error and the word is dropped.
  - Writing while the FIFO is full sets error and the word is dropped.
- Message input parser, tracking in_remaining:
  - Header (MSB=1) with in_remaining==0: write it; in_remaining<=L. If L==0, complete_count increments.
  - Header with in_remaining!=0: error set; the header is still accepted and restarts parsing as above.
  - Content (MSB=0) with in_remaining!=0: write it; in_remaining decrements; on reaching 0, complete_count increments.
  - Content with in_remaining==0: error set, word dropped.
  - Message FIFO full on any write: error set, word dropped. Further stream integrity is undefined until reset.
- complete_count (width MSG_BUF_LOG+1) counts fully buffered messages. It increments on message completion and decrements when a header is popped. Both in one cycle leave it unchanged.
- Output FSM, at most one pop per cycle:
  - IDLE, complete_count>0: pop header, drive out_data=header, out_nd=1, out_remaining<=L. Go to MSG if L>0, else stay in IDLE.
  - IDLE, complete_count==0 and sample FIFO non-empty: pop a sample and output it with out_nd=1.
  - IDLE, neither available: out_nd=0.
  - MSG: pop one message word per cycle (guaranteed present) and output it. out_remaining decrements; when it goes 1->0, return to IDLE. Samples wait.
- Latency: a word written at edge k is at the earliest output with out_nd=1 after edge k+1. Outputs are registered.
- A message word arriving and its message completing on the same edge are handled by the counter rule above.
- error stays high until reset and never stalls the data path.
- Throughput: 1 output word/cycle. Sustained combined input rate above 1 word/cycle eventually overflows a FIFO and sets error.

Decomposition:
- `MSG_LENGTH_WIDTH` stays in the shared message defines header. Add header-bit index and length-field slice macros there for reuse by splitter and combiner.
- Sub-module: sync_fifo (WIDTH, LOG_DEPTH). Single clock, async active-low reset, write/read/full/empty/count. Instantiated twice.

Test Plan:
- Samples only: 0x00000001..0x00000005 on consecutive cycles -> same five words out, in order, out_nd high 5 cycles, error=0.
- Message only: header L=2 then 0x0000000A, 0x0000000B -> header, 0xA, 0xB out on 3 consecutive cycles, starting no earlier than one cycle after the last content word is written.
- Interleave:
  - Input: samples 0x11, 0x12, 0x13 every cycle, plus header L=1 and content 0x0000AAAA arriving with gaps.
  - Required: the message emerges contiguous, with no sample between header and content.
  - Required: all samples are emitted, in order.
- Zero-length header (L=0) followed by a sample 0x21 -> header output alone, then 0x21; complete_count back to 0.
- Protocol errors, each checked on a fresh reset:
  - Sample 0x80000000: error rises, word not output.
  - Content word with no header: error rises, word dropped.
  - 17 samples in one burst with out blocked by a pending message (SAMPLE_BUF_LOG=4): error rises.
- Asynchronous reset mid-message (after header plus one of three content words): out_nd=0 and error=0 immediately. A fresh sample afterwards passes normally.
